spi_config_sequencer: RTL and testbench
=======================================

Name: spi_config_sequencer

Overview:
- Upstream command source for the sensor SPI transmit engine.
- Walks a table of (7-bit address, 8-bit data) register settings, builds the engine's 32-bit command word, and paces one transaction at a time using the engine's state output.
- Optional verify pass reads each register back after writing it and counts mismatches.
- Replaces manual host command words during sensor bring-up; the host only starts and monitors it.

Parameters:
NUM_REGS, 16, number of table entries walked per run (1..128)
IDX_W, 7, width of table index (must satisfy 2**IDX_W >= NUM_REGS)
TIMEOUT_CYCLES, 16'd1023, max FSM_CLK cycles waiting on any single engine state before error
ENG_IDLE_1, 8'd3, engine state value meaning ready/idle
ENG_IDLE_2, 8'd9, engine state value meaning transaction complete

Ports:
FSM_CLK  in  1  system clock (80 MHz), all logic on rising edge
RST  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse: begin run; ignored while busy
cfg_verify  in  1  sampled on accepted cfg_start; 1 = write then read back each entry
cfg_power_off  in  1  pulse: drop sensor power; honoured only in IDLE/DONE/ERROR
eng_state  in  8  engine state output
eng_rdata  in  8  engine read-data output
cmd_word  out  32  to engine: [31] power_on, [30] spi_start, [29] C (1=write), [28:22] address, [21:14] write data, [13:0] zero
busy  out  1  high from accepted start until DONE/ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR (timeout)
cur_index  out  IDX_W  entry currently being processed
mismatch_cnt  out  8  saturating count of verify mismatches this run
last_rdata  out  8  data captured on most recent read

Behaviour:
- Reset (sync, active-high): every output 0, including cmd_word; state IDLE. Asserting RST mid-transaction aborts immediately; spi_start and power_on drop the next edge.
- cmd_word is fully registered. Bits [13:0] are always 0.
- States and transitions:
  - IDLE: on cfg_start, latch verify, clear mismatch_cnt and cur_index, set power_on=1, go PWR_WAIT. power_on stays 1 through DONE/ERROR until cfg_power_off or RST.
  - PWR_WAIT: spi_start=0; wait eng_state==ENG_IDLE_1 (engine start-up of ~102 cycles), then go LOAD.
  - LOAD: present cur_index to the ROM; 1-cycle read latency; register {addr, data} into cmd_word[28:14]; set C=1; go ISSUE.
  - ISSUE: spi_start=1; go WAIT_DONE.
  - WAIT_DONE: hold the command word stable; wait eng_state==ENG_IDLE_2. On the read pass, capture eng_rdata into last_rdata at this cycle. Go RELEASE.
  - RELEASE: spi_start=0; wait eng_state==ENG_IDLE_1.
    - If verify is set and C was 1: set C=0, keep the address, go ISSUE.
    - If C was 0: go CHECK.
    - Otherwise go NEXT.
  - CHECK: if last_rdata != table data, increment mismatch_cnt, saturating at 255. Mismatches never abort the run. Go NEXT.
  - NEXT: if cur_index==NUM_REGS-1 go DONE, else increment cur_index and go LOAD.
  - DONE / ERROR: busy=0. cfg_start begins a new run (re-enters PWR_WAIT; engine already idle so passes in 1 cycle). cfg_power_off clears power_on and returns to IDLE.
- Timeout: a 16-bit counter clears on every state change. If it reaches TIMEOUT_CYCLES in PWR_WAIT, WAIT_DONE or RELEASE: go ERROR, clear spi_start, keep power_on.
- cfg_start while busy: ignored. cfg_power_off while busy: ignored.
- Simultaneous cfg_start and cfg_power_off in DONE: power_off wins.
- Nominal latency per write entry is ~37 cycles (engine 35 + LOAD + ISSUE); verify roughly doubles this.

Decomposition:
- Shared package spi_cfg_pkg:
  - command-word bit positions (POWER_BIT=31, START_BIT=30, C_BIT=29, ADDR_MSB/LSB=28/22, DATA_MSB/LSB=21/14);
  - engine state encodings ENG_IDLE_1/ENG_IDLE_2;
  - sequencer state localparams.
- One sub-module, spi_config_rom: synchronous read, IDX_W index in, 15-bit {addr, data} out. Holds the register table; initialised from a memory file. Indices >= NUM_REGS read 0.

Test Plan:
- NUM_REGS=3, table {0x10:0xA5, 0x22:0x3C, 0x7F:0x01}, verify=0, behavioural engine stub -> three transactions in order; cmd_word[28:14] matches each entry while spi_start=1; done=1, error=0, power_on stays 1.
- Same table, verify=1, stub echoes written data -> six transactions alternating C=1/C=0 at the same address; mismatch_cnt=0; last_rdata=0x01.
- Verify=1, stub returns 0xFF on reads -> mismatch_cnt=3, done=1 (no abort).
- Stub stuck in a non-idle state after the first spi_start -> error=1 exactly TIMEOUT_CYCLES after entering WAIT_DONE; spi_start=0; power_on=1.
- RST asserted mid-WAIT_DONE of entry 1 -> next edge cmd_word=0, busy=0; a fresh cfg_start restarts from index 0.
- cfg_start pulsed during a run, then cfg_power_off in DONE -> the start is ignored; the power-off clears bit 31 and returns to IDLE.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration sequencer: command-word layout,
// engine handshake encodings, sequencer states and the default register table.
package spi_cfg_pkg;

    // Command-word bit positions seen by the SPI transmit engine
    localparam int POWER_BIT = 31;
    localparam int START_BIT = 30;
    localparam int C_BIT     = 29;
    localparam int ADDR_MSB  = 28;
    localparam int ADDR_LSB  = 22;
    localparam int DATA_MSB  = 21;
    localparam int DATA_LSB  = 14;

    // One table entry is {7-bit address, 8-bit data}
    localparam int ENTRY_W = 15;

    // Engine state values the sequencer paces against
    localparam logic [7:0] ENG_IDLE_1 = 8'd3;  // ready / idle
    localparam logic [7:0] ENG_IDLE_2 = 8'd9;  // transaction complete

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_LOAD,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_CHECK,
        S_NEXT,
        S_DONE,
        S_ERROR
    } seq_state_e;

    // Default 16-entry bring-up table, entry 0 in the least significant slot
    localparam logic [16*ENTRY_W-1:0] DEFAULT_ROM = {
        7'h0F, 8'h00, 7'h0E, 8'h00, 7'h0D, 8'h00, 7'h0C, 8'h00,
        7'h0B, 8'h00, 7'h0A, 8'h00, 7'h09, 8'h00, 7'h08, 8'h00,
        7'h07, 8'h40, 7'h06, 8'h22, 7'h05, 8'h10, 7'h04, 8'h08,
        7'h03, 8'h04, 7'h02, 8'h02, 7'h01, 8'h80, 7'h00, 8'h01
    };

endpackage

// File: rtl/spi_config_rom.sv
// Register-settings table with a synchronous read port. Contents are fixed at
// elaboration from ROM_INIT; indices at or beyond NUM_REGS read as zero.
module spi_config_rom
    import spi_cfg_pkg::*;
#(
    parameter int                          NUM_REGS = 16,
    parameter int                          IDX_W    = 7,
    parameter logic [NUM_REGS*ENTRY_W-1:0] ROM_INIT = DEFAULT_ROM
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    logic [ENTRY_W-1:0] table_w [2**IDX_W];
    logic [ENTRY_W-1:0] entry_q;

    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_tbl
        if (g < NUM_REGS) begin : g_used
            assign table_w[g] = ROM_INIT[g*ENTRY_W +: ENTRY_W];
        end else begin : g_unused
            assign table_w[g] = '0;
        end
    end

    // Registered read: data for idx_i appears one cycle later
    // NOTE: the table is constant and needs no reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= table_w[idx_i];
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/spi_config_sequencer.sv
// Walks the register table, builds the engine's 32-bit command word and paces
// one SPI transaction at a time on the engine state. Optional read-back verify.
module spi_config_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int                          NUM_REGS       = 16,
    parameter int                          IDX_W          = 7,
    parameter logic [15:0]                 TIMEOUT_CYCLES = 16'd1023,
    parameter logic [7:0]                  ENG_IDLE_1     = spi_cfg_pkg::ENG_IDLE_1,
    parameter logic [7:0]                  ENG_IDLE_2     = spi_cfg_pkg::ENG_IDLE_2,
    parameter logic [NUM_REGS*ENTRY_W-1:0] ROM_INIT       = DEFAULT_ROM
) (
    input  logic             FSM_CLK,
    input  logic             RST,
    input  logic             cfg_start,
    input  logic             cfg_verify,
    input  logic             cfg_power_off,
    input  logic [7:0]       eng_state,
    input  logic [7:0]       eng_rdata,
    output logic [31:0]      cmd_word,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] cur_index,
    output logic [7:0]       mismatch_cnt,
    output logic [7:0]       last_rdata
);

    seq_state_e         state_q, state_d;
    logic [15:0]        tmo_q, tmo_d;
    logic [31:0]        cmd_q, cmd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               verify_q, verify_d;
    logic [7:0]         mis_q, mis_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [ENTRY_W-1:0] rom_entry;
    logic [15:0]        tmo_inc;
    logic               tmo_hit;

    spi_config_rom #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk_i   (FSM_CLK),
        .rst_i   (RST),
        .idx_i   (idx_q),
        .entry_o (rom_entry)
    );

    assign tmo_inc = tmo_q + 16'd1;
    assign tmo_hit = (tmo_inc == TIMEOUT_CYCLES);

    // Next-state, command-word and bookkeeping logic
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_inc;
        cmd_d    = cmd_q;
        idx_d    = idx_q;
        verify_d = verify_q;
        mis_d    = mis_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // Power-off takes priority over a simultaneous start
                if (cfg_power_off) begin
                    cmd_d   = '0;
                    state_d = S_IDLE;
                end else if (cfg_start) begin
                    verify_d         = cfg_verify;
                    mis_d            = '0;
                    idx_d            = '0;
                    cmd_d[POWER_BIT] = 1'b1;
                    state_d          = S_PWR_WAIT;
                end
            end
            S_PWR_WAIT: begin
                cmd_d[START_BIT] = 1'b0;
                if (eng_state == ENG_IDLE_1) begin
                    state_d = S_LOAD;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_LOAD: begin
                // ROM is reading idx_q this cycle; its data is used in ISSUE
                cmd_d[C_BIT] = 1'b1;
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_d[START_BIT] = 1'b1;
                // Write pass loads fresh table data; read pass keeps the address
                if (cmd_q[C_BIT]) begin
                    cmd_d[ADDR_MSB:DATA_LSB] = rom_entry;
                end
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (eng_state == ENG_IDLE_2) begin
                    if (!cmd_q[C_BIT]) begin
                        rdata_d = eng_rdata;
                    end
                    state_d = S_RELEASE;
                end else if (tmo_hit) begin
                    cmd_d[START_BIT] = 1'b0;
                    state_d          = S_ERROR;
                end
            end
            S_RELEASE: begin
                cmd_d[START_BIT] = 1'b0;
                if (eng_state == ENG_IDLE_1) begin
                    if (!cmd_q[C_BIT]) begin
                        state_d = S_CHECK;
                    end else if (verify_q) begin
                        cmd_d[C_BIT] = 1'b0;
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_CHECK: begin
                // Data field still holds the table value written for this entry
                if (rdata_q != cmd_q[DATA_MSB:DATA_LSB] && mis_q != 8'hFF) begin
                    mis_d = mis_q + 8'd1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            default: begin
                cmd_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // The timeout counter measures time spent in the current state only
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    // State and datapath registers with synchronous reset
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge FSM_CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            cmd_q    <= '0;
            idx_q    <= '0;
            verify_q <= 1'b0;
            mis_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            verify_q <= verify_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cmd_word     = cmd_q;
    assign busy         = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign cur_index    = idx_q;
    assign mismatch_cnt = mis_q;
    assign last_rdata   = rdata_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Bench for spi_config_sequencer: behavioural engine stub, transaction
// scoreboard, table-driven runs and hand-written corner sequences.
module tb_spi_config_sequencer;
    import spi_cfg_pkg::*;

    localparam int          NREGS = 3;
    localparam int          IDXW  = 7;
    localparam logic [15:0] TMO   = 16'd1023;
    localparam logic [NREGS*ENTRY_W-1:0] TB_ROM = {7'h7F, 8'h01, 7'h22, 8'h3C, 7'h10, 8'hA5};
    localparam logic [6:0]  TBL_ADDR [NREGS] = '{7'h10, 7'h22, 7'h7F};
    localparam logic [7:0]  TBL_DATA [NREGS] = '{8'hA5, 8'h3C, 8'h01};
    localparam int          PWR_UP_CYCLES = 20;
    localparam int          BUSY_CYCLES   = 8;

    typedef enum logic [1:0] {M_ECHO, M_FF, M_STUCK} stub_mode_e;

    typedef struct packed {
        logic       c;
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        logic       verify;
        stub_mode_e mode;
        logic [7:0] exp_mis;
        logic [7:0] exp_rdata;
        int         exp_txn;
    } run_vec_t;

    logic            FSM_CLK;
    logic            RST;
    logic            cfg_start;
    logic            cfg_verify;
    logic            cfg_power_off;
    logic [7:0]      eng_state;
    logic [7:0]      eng_rdata;
    logic [31:0]     cmd_word;
    logic            busy;
    logic            done;
    logic            error;
    logic [IDXW-1:0] cur_index;
    logic [7:0]      mismatch_cnt;
    logic [7:0]      last_rdata;

    stub_mode_e mode;
    txn_t       sb [$];
    int         n_checks;
    int         n_fail;
    int         txn_cnt;
    logic       prev_start;
    logic       start_rise;
    run_vec_t   vecs [4];

    spi_config_sequencer #(
        .NUM_REGS       (NREGS),
        .IDX_W          (IDXW),
        .TIMEOUT_CYCLES (TMO),
        .ROM_INIT       (TB_ROM)
    ) dut (
        .FSM_CLK       (FSM_CLK),
        .RST           (RST),
        .cfg_start     (cfg_start),
        .cfg_verify    (cfg_verify),
        .cfg_power_off (cfg_power_off),
        .eng_state     (eng_state),
        .eng_rdata     (eng_rdata),
        .cmd_word      (cmd_word),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .cur_index     (cur_index),
        .mismatch_cnt  (mismatch_cnt),
        .last_rdata    (last_rdata)
    );

    initial begin
        FSM_CLK = 1'b0;
        forever #5 FSM_CLK = ~FSM_CLK;
    end

    // Engine stub: power-up delay, busy period per transaction, completion
    // held until spi_start drops. Echo mode returns the last written data.
    int         eng_cnt;
    logic [7:0] eng_mem [128];
    always @(posedge FSM_CLK) begin
        if (RST || !cmd_word[POWER_BIT]) begin
            eng_state <= 8'd0;
            eng_rdata <= 8'd0;
            eng_cnt   <= 0;
        end else begin
            case (eng_state)
                8'd0: begin
                    if (eng_cnt == PWR_UP_CYCLES - 1) begin
                        eng_state <= ENG_IDLE_1;
                        eng_cnt   <= 0;
                    end else begin
                        eng_cnt <= eng_cnt + 1;
                    end
                end
                ENG_IDLE_1: begin
                    if (cmd_word[START_BIT]) begin
                        eng_state <= 8'd5;
                        eng_cnt   <= 0;
                    end
                end
                8'd5: begin
                    if (mode != M_STUCK) begin
                        if (eng_cnt == BUSY_CYCLES - 1) begin
                            eng_state <= ENG_IDLE_2;
                            if (cmd_word[C_BIT]) begin
                                eng_mem[cmd_word[ADDR_MSB:ADDR_LSB]] <= cmd_word[DATA_MSB:DATA_LSB];
                            end else begin
                                eng_rdata <= (mode == M_FF) ? 8'hFF : eng_mem[cmd_word[ADDR_MSB:ADDR_LSB]];
                            end
                        end else begin
                            eng_cnt <= eng_cnt + 1;
                        end
                    end
                end
                ENG_IDLE_2: begin
                    if (!cmd_word[START_BIT]) begin
                        eng_state <= ENG_IDLE_1;
                    end
                end
                default: eng_state <= 8'd0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock step; samples on the falling edge and scores each new transaction
    task automatic tick();
        txn_t e;
        @(negedge FSM_CLK);
        start_rise = cmd_word[START_BIT] && !prev_start;
        prev_start = cmd_word[START_BIT];
        if (start_rise) begin
            txn_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_txn: actual cmd_word=0x%08h required no transaction", cmd_word);
            end else begin
                e = sb.pop_front();
                check("txn_c", 32'(cmd_word[C_BIT]), 32'(e.c));
                check("txn_addr", 32'(cmd_word[ADDR_MSB:ADDR_LSB]), 32'(e.addr));
                if (e.c) begin
                    check("txn_wdata", 32'(cmd_word[DATA_MSB:DATA_LSB]), 32'(e.data));
                end
                check("txn_low_bits", 32'(cmd_word[13:0]), 32'd0);
                check("txn_power", 32'(cmd_word[POWER_BIT]), 32'd1);
            end
        end
    endtask

    task automatic push_run(input logic verify);
        for (int i = 0; i < NREGS; i++) begin
            sb.push_back('{1'b1, TBL_ADDR[i], TBL_DATA[i]});
            if (verify) begin
                sb.push_back('{1'b0, TBL_ADDR[i], TBL_DATA[i]});
            end
        end
    endtask

    task automatic pulse_start(input logic verify);
        cfg_start  = 1'b1;
        cfg_verify = verify;
        tick();
        cfg_start  = 1'b0;
        cfg_verify = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_finished"}, 32'(done || error), 32'd1);
    endtask

    task automatic wait_txn(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (txn_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_txn_seen"}, 32'(txn_cnt), 32'(target));
    endtask

    initial begin
        int k;
        RST           = 1'b1;
        cfg_start     = 1'b0;
        cfg_verify    = 1'b0;
        cfg_power_off = 1'b0;
        mode          = M_ECHO;
        prev_start    = 1'b0;
        start_rise    = 1'b0;
        n_checks      = 0;
        n_fail        = 0;
        txn_cnt       = 0;

        vecs[0] = '{1'b0, M_ECHO, 8'd0, 8'h00, 3};
        vecs[1] = '{1'b1, M_ECHO, 8'd0, 8'h01, 6};
        vecs[2] = '{1'b1, M_FF,   8'd3, 8'hFF, 6};
        vecs[3] = '{1'b0, M_ECHO, 8'd0, 8'hFF, 3};

        // Reset state
        repeat (3) tick();
        check("rst_cmd_word", cmd_word, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cur_index", 32'(cur_index), 32'd0);
        check("rst_mismatch", 32'(mismatch_cnt), 32'd0);
        check("rst_last_rdata", 32'(last_rdata), 32'd0);
        RST = 1'b0;
        tick();

        // Table-driven runs, each starting from the previous DONE
        for (int i = 0; i < 4; i++) begin
            mode    = vecs[i].mode;
            txn_cnt = 0;
            push_run(vecs[i].verify);
            pulse_start(vecs[i].verify);
            wait_end($sformatf("run%0d", i), 3000);
            check($sformatf("run%0d_done", i), 32'(done), 32'd1);
            check($sformatf("run%0d_error", i), 32'(error), 32'd0);
            check($sformatf("run%0d_power", i), 32'(cmd_word[POWER_BIT]), 32'd1);
            check($sformatf("run%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("run%0d_mismatch", i), 32'(mismatch_cnt), 32'(vecs[i].exp_mis));
            check($sformatf("run%0d_last_rdata", i), 32'(last_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("run%0d_txns", i), 32'(txn_cnt), 32'(vecs[i].exp_txn));
            check($sformatf("run%0d_sb_left", i), 32'(sb.size()), 32'd0);
            check($sformatf("run%0d_index", i), 32'(cur_index), 32'(NREGS - 1));
            sb.delete();
        end

        // Start and power-off while busy are ignored; power-off wins over start in DONE
        txn_cnt = 0;
        push_run(1'b0);
        pulse_start(1'b0);
        repeat (5) tick();
        pulse_start(1'b1);
        repeat (3) tick();
        cfg_power_off = 1'b1;
        tick();
        cfg_power_off = 1'b0;
        check("busy_pwroff_power_kept", 32'(cmd_word[POWER_BIT]), 32'd1);
        check("busy_pwroff_still_busy", 32'(busy), 32'd1);
        wait_end("ignored_start", 3000);
        check("ignored_start_done", 32'(done), 32'd1);
        check("ignored_start_txns", 32'(txn_cnt), 32'd3);
        check("ignored_start_sb_left", 32'(sb.size()), 32'd0);
        sb.delete();
        cfg_start     = 1'b1;
        cfg_power_off = 1'b1;
        tick();
        cfg_start     = 1'b0;
        cfg_power_off = 1'b0;
        check("pwroff_power_bit", 32'(cmd_word[POWER_BIT]), 32'd0);
        check("pwroff_busy", 32'(busy), 32'd0);
        check("pwroff_done", 32'(done), 32'd0);
        repeat (5) tick();
        check("pwroff_idle_busy", 32'(busy), 32'd0);
        check("pwroff_idle_cmd", cmd_word, 32'd0);

        // Engine stuck after the first spi_start: timeout from WAIT_DONE entry
        mode    = M_STUCK;
        txn_cnt = 0;
        sb.push_back('{1'b1, TBL_ADDR[0], TBL_DATA[0]});
        pulse_start(1'b0);
        wait_txn("stuck", 1, 500);
        k = 0;
        while (!error && k < 2000) begin
            tick();
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TMO));
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_done", 32'(done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_spi_start", 32'(cmd_word[START_BIT]), 32'd0);
        check("timeout_power", 32'(cmd_word[POWER_BIT]), 32'd1);
        sb.delete();

        // Reset in the middle of entry 1, then a clean restart from index 0
        RST = 1'b1;
        tick();
        RST     = 1'b0;
        mode    = M_ECHO;
        txn_cnt = 0;
        push_run(1'b0);
        pulse_start(1'b0);
        wait_txn("mid_rst", 2, 1000);
        check("mid_rst_index_before", 32'(cur_index), 32'd1);
        repeat (2) tick();
        RST = 1'b1;
        tick();
        check("mid_rst_cmd_word", cmd_word, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_index", 32'(cur_index), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        RST = 1'b0;
        sb.delete();
        txn_cnt = 0;
        push_run(1'b0);
        pulse_start(1'b0);
        wait_end("restart", 3000);
        check("restart_done", 32'(done), 32'd1);
        check("restart_txns", 32'(txn_cnt), 32'd3);
        check("restart_sb_left", 32'(sb.size()), 32'd0);
        check("restart_index", 32'(cur_index), 32'(NREGS - 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
